// File: rtl/myproject_mul_arb.sv
// ============================================================================
// myproject_mul_arb
//
// Purpose:
//    Shares a single registered signed multiplier among NUM_REQ requesters.
//    A round-robin arbiter picks one requester per cycle. The winner's
//    operands go through the multiplier, and the full-precision product is
//    captured in a one-deep output stage together with the winner's index.
//    The output stage uses a valid/ready handshake. It accepts a new result
//    whenever it is empty or its current result is being consumed, so the
//    block sustains one result per cycle with a latency of one cycle.
//
// Ports:
//    clk        in   1                     rising-edge clock
//    reset      in   1                     asynchronous reset, active low
//    req_valid  in   NUM_REQ               per-requester operand valid
//    req_ready  out  NUM_REQ               per-requester accept (one-hot or 0)
//    req_din0   in   NUM_REQ*din0_WIDTH    packed signed operand A
//    req_din1   in   NUM_REQ*din1_WIDTH    packed signed operand B
//    out_valid  out  1                     result valid
//    out_ready  in   1                     consumer accept
//    out_data   out  dout_WIDTH            signed product
//    out_id     out  ID_W                  index of the requester owning out_data
// ============================================================================
module myproject_mul_arb #(
    parameter int NUM_REQ    = 4,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 22,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*din0_WIDTH-1:0] req_din0,
    input  logic [NUM_REQ*din1_WIDTH-1:0] req_din1,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [dout_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_id
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   r_outValid;
    logic [dout_WIDTH-1:0]  r_outData;
    logic [ID_W-1:0]        r_outId;
    logic [ID_W-1:0]        r_lastGrant;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                          w_advance;
    logic                          w_found;
    logic [ID_W-1:0]               w_winner;
    logic [ID_W-1:0]               w_cand;
    logic                          w_transfer;
    logic signed [din0_WIDTH-1:0]  w_opA;
    logic signed [din1_WIDTH-1:0]  w_opB;
    logic signed [dout_WIDTH-1:0]  w_extA;
    logic signed [dout_WIDTH-1:0]  w_extB;
    logic signed [dout_WIDTH-1:0]  w_product;

    // The output stage can take a new value when it is empty or when the
    // value it holds is being consumed on this edge. This one term is the
    // clock enable for the whole stage.
    assign w_advance = !r_outValid || out_ready;

    // Round-robin search. Walk upward from the requester after the last
    // grant and wrap around. The last grant itself is visited last, at
    // offset NUM_REQ, so a lone active requester still wins every cycle.
    // The first valid requester found wins. The search uses only
    // req_valid and r_lastGrant, so the grant never depends on operand data.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = ID_W'((int'(r_lastGrant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // A transfer happens only when the stage can advance and a requester
    // is waiting. The reset term keeps req_ready low for as long as reset
    // is held, even though the empty stage would otherwise report advance.
    assign w_transfer = reset && w_advance && w_found;

    // Drive the accept strobe to the winner only. The result is one-hot or
    // all zero by construction.
    always_comb begin
        req_ready = '0;
        if (w_transfer) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    // Steer the winner's operand slices into the shared multiplier. A
    // compare against each constant index keeps every part-select static.
    always_comb begin
        w_opA = '0;
        w_opB = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_opA = req_din0[i*din0_WIDTH +: din0_WIDTH];
                w_opB = req_din1[i*din1_WIDTH +: din1_WIDTH];
            end
        end
    end

    // Sign-extend both operands to the full product width before
    // multiplying. The low dout_WIDTH bits of the product are then the
    // exact signed result. Because dout_WIDTH = din0_WIDTH + din1_WIDTH,
    // no value can overflow, so there is no truncation or saturation.
    assign w_extA    = {{(dout_WIDTH-din0_WIDTH){w_opA[din0_WIDTH-1]}}, w_opA};
    assign w_extB    = {{(dout_WIDTH-din1_WIDTH){w_opB[din1_WIDTH-1]}}, w_opB};
    assign w_product = w_extA * w_extB;

    // Output stage and arbitration pointer.
    // Reset empties the stage immediately and drops any in-flight result.
    // It also parks the pointer on the top index, so requester 0 is first
    // in line after release.
    // When the stage cannot advance, all three stage values hold
    // bit-stable. On an advance edge without a transfer, only the valid
    // flag clears; data and id keep their old contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outId     <= '0;
            r_lastGrant <= ID_W'(NUM_REQ-1);
        end else if (w_advance) begin
            r_outValid <= w_transfer;
            if (w_transfer) begin
                r_outData   <= w_product;
                r_outId     <= w_winner;
                r_lastGrant <= w_winner;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_id    = r_outId;

endmodule

// File: tb/tb_myproject_mul_arb.sv
// ============================================================================
// tb_myproject_mul_arb
//
// Self-checking bench for myproject_mul_arb at its default parameters.
// A behavioural model tracks what the outputs should show: the last grant,
// the presented result and its owner. It picks the grant by scanning the
// request vector from the slot after the last grant. It computes products
// with plain integer arithmetic.
// ============================================================================
module tb_myproject_mul_arb;

    localparam int N  = 4;
    localparam int WA = 16;
    localparam int WB = 6;
    localparam int WD = 22;
    localparam int WI = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*WA-1:0] req_din0;
    logic [N*WB-1:0] req_din1;
    logic            out_valid;
    logic            out_ready;
    logic [WD-1:0]   out_data;
    logic [WI-1:0]   out_id;

    int vecCount  = 0;
    int missCount = 0;

    // Reference model state
    int            mLast;
    logic          mValid;
    logic [WD-1:0] mData;
    logic [WI-1:0] mId;
    int            mGrant;

    // Random-phase requester bookkeeping
    logic [N-1:0]  pend;
    logic [WA-1:0] ra [N];
    logic [WB-1:0] rb [N];
    logic [N*WA-1:0] pa;
    logic [N*WB-1:0] pb;

    int seq [6] = '{0, 1, 2, 3, 0, 1};

    myproject_mul_arb #(
        .NUM_REQ    (N),
        .din0_WIDTH (WA),
        .din1_WIDTH (WB),
        .dout_WIDTH (WD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Signed product by plain integer arithmetic, kept to the output width
    function automatic logic [WD-1:0] refProduct(input logic [WA-1:0] a, input logic [WB-1:0] b);
        int sa;
        int sb;
        int p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = sa * sb;
        return p[WD-1:0];
    endfunction

    // Put the model into its post-reset state
    task automatic modelReset();
        mLast  = N - 1;
        mValid = 1'b0;
        mData  = '0;
        mId    = '0;
        mGrant = -1;
    endtask

    // One clock cycle. Inputs are driven just after a rising edge. Outputs
    // and req_ready are checked at the falling edge against the model, and
    // the model then advances as the DUT will on the next rising edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*WA-1:0] a,
                                 input logic [N*WB-1:0] b, input logic ordy);
        logic         adv;
        logic [N-1:0] expReady;
        int           g;
        req_valid = v;
        req_din0  = a;
        req_din1  = b;
        out_ready = ordy;
        @(negedge clk);
        adv = !mValid || ordy;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && v[(mLast + k) % N]) g = (mLast + k) % N;
        end
        expReady = (adv && g >= 0) ? N'(1 << g) : '0;
        checkOutput("out_valid", 32'(out_valid), 32'(mValid));
        checkOutput("out_data",  32'(out_data),  32'(mData));
        checkOutput("out_id",    32'(out_id),    32'(mId));
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        mGrant = (adv && g >= 0) ? g : -1;
        if (adv) begin
            mValid = (g >= 0);
            if (g >= 0) begin
                mData = refProduct(a[g*WA +: WA], b[g*WB +: WB]);
                mId   = WI'(g);
                mLast = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        out_ready = 1'b0;
        modelReset();

        // While reset is held, the outputs are zero and nothing is accepted,
        // even with every requester asking.
        req_valid = 4'b1111;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data",  32'(out_data),  32'd0);
        checkOutput("rst_id",    32'(out_id),    32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;

        // Single request, accepted on the first edge after release
        applyStimulus(4'b0001, {48'h0, 16'hFFFD}, {18'h0, 6'h05}, 1'b1);
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_data",  32'(out_data),  32'h3FFFF1);
        checkOutput("single_id",    32'(out_id),    32'd0);

        // Extreme operands
        applyStimulus(4'b0001, {48'h0, 16'h8000}, {18'h0, 6'h20}, 1'b1);
        checkOutput("ext_min_min", 32'(out_data), 32'h100000);
        applyStimulus(4'b0001, {48'h0, 16'h7FFF}, {18'h0, 6'h20}, 1'b1);
        checkOutput("ext_max_min", 32'(out_data), 32'h300020);

        // Move the pointer to 3, then check the full rotation
        applyStimulus(4'b1000, {16'd7, 48'h0}, {6'd3, 18'h0}, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {6'd1, 6'd1, 6'd1, 6'd1}, 1'b1);
            checkOutput("rr_valid", 32'(out_valid), 32'd1);
            checkOutput("rr_id",    32'(out_id),    32'(seq[i]));
        end

        // Backpressure: the result holds and nothing is accepted
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, {48'h0, 16'hFFFF}, {18'h0, 6'h3F}, 1'b0);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_id",    32'(out_id),    32'd1);
        end
        applyStimulus(4'b0001, {48'h0, 16'hFFFF}, {18'h0, 6'h3F}, 1'b1);
        checkOutput("bp_release_id",   32'(out_id),   32'd0);
        checkOutput("bp_release_data", 32'(out_data), 32'd1);

        // Skip and wrap: set the pointer to 2, then request 0 and 2
        applyStimulus(4'b0100, {32'h0, 16'd5, 16'h0}, {12'h0, 6'd2, 6'h0}, 1'b1);
        applyStimulus(4'b0101, {32'h0, 16'd5, 16'd9}, {12'h0, 6'd2, 6'd2}, 1'b1);
        checkOutput("wrap_first", 32'(out_id), 32'd0);
        applyStimulus(4'b0101, {32'h0, 16'd5, 16'd9}, {12'h0, 6'd2, 6'd2}, 1'b1);
        checkOutput("wrap_second", 32'(out_id), 32'd2);
        checkOutput("wrap_valid",  32'(out_valid), 32'd1);

        // Asynchronous reset between edges while a result is presented
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_data",  32'(out_data),  32'd0);
        checkOutput("mid_rst_id",    32'(out_id),    32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_hold", 32'(out_valid), 32'd0);
        reset = 1'b1;
        applyStimulus(4'b1010, {16'd3, 16'd0, 16'hFFFE, 16'd0}, {6'd1, 6'd0, 6'd7, 6'd0}, 1'b1);
        checkOutput("post_rst_id",   32'(out_id),   32'd1);
        checkOutput("post_rst_data", 32'(out_data), 32'h3FFFF2);

        // Random traffic. Requesters mostly hold requests until accepted
        // and occasionally give up. The consumer stalls about 30% of the time.
        pend = '0;
        for (int r = 0; r < N; r++) begin
            ra[r] = '0;
            rb[r] = '0;
        end
        for (int it = 0; it < 400; it++) begin
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && $urandom_range(0, 99) < 40) begin
                    pend[r] = 1'b1;
                    ra[r]   = WA'($urandom);
                    rb[r]   = WB'($urandom);
                end else if (pend[r] && $urandom_range(0, 99) < 5) begin
                    pend[r] = 1'b0;
                end
            end
            for (int r = 0; r < N; r++) begin
                pa[r*WA +: WA] = ra[r];
                pb[r*WB +: WB] = rb[r];
            end
            applyStimulus(pend, pa, pb, $urandom_range(0, 99) < 70);
            if (mGrant >= 0) pend[mGrant] = 1'b0;
        end

        applyStimulus('0, '0, '0, 1'b1);
        applyStimulus('0, '0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/myproject_mul_arb.md
MYPROJECT_MUL_ARB -- requirements
Module: myproject_mul_arb

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters; legal values are 2..8.
REQ-002 The block SHALL have parameter din0_WIDTH, default 16, giving the signed operand A width.
REQ-003 The block SHALL have parameter din1_WIDTH, default 6, giving the signed operand B width.
REQ-004 The block SHALL have parameter dout_WIDTH, default 22, giving the product width; it equals din0_WIDTH+din1_WIDTH.
REQ-005 The block SHALL have derived localparam ID_W = max(1, clog2(NUM_REQ)).

Ports (name, direction, width, meaning):
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port reset, input, 1, the reset; it is asynchronous and active-low (0 = reset asserted).
REQ-008 The block SHALL have port req_valid, input, NUM_REQ, per-requester operand valid.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ, per-requester accept; at most one bit is high per cycle.
REQ-010 The block SHALL have port req_din0, input, NUM_REQ*din0_WIDTH, packed operand A; requester i occupies slice [i*din0_WIDTH +: din0_WIDTH].
REQ-011 The block SHALL have port req_din1, input, NUM_REQ*din1_WIDTH, packed operand B, packed the same way.
REQ-012 The block SHALL have port out_valid, output, 1, result valid.
REQ-013 The block SHALL have port out_ready, input, 1, consumer accept.
REQ-014 The block SHALL have port out_data, output, dout_WIDTH, signed product.
REQ-015 The block SHALL have port out_id, output, ID_W, index of the requester that owns out_data.

Function
REQ-016 The block SHALL share one signed multiplier, with one registered stage and a clock enable, among all requesters.
REQ-017 The multiplier stage SHALL compute $signed(A)*$signed(B) at full dout_WIDTH precision, with no truncation or saturation.
REQ-018 The block SHALL define advance = !out_valid || out_ready.
REQ-019 The stage register (data, id, valid) SHALL load only when advance=1; when advance=0 it SHALL hold all three values bit-stable.
REQ-020 Arbitration SHALL be round-robin over req_valid, searching upward from index (last_grant+1) mod NUM_REQ and wrapping.
REQ-021 The arbiter output SHALL be combinational within the cycle.
REQ-022 req_ready[g] SHALL be 1 only when advance=1, req_valid[g]=1 and g is the arbiter winner; all other req_ready bits SHALL be 0.
REQ-023 req_ready SHALL NOT depend on req_din0 or req_din1.
REQ-024 A transfer SHALL occur on an edge where req_valid[g] && req_ready[g]; on that edge the stage loads the product of slice g, sets out_id=g and sets out_valid=1.
REQ-025 last_grant SHALL update to g only on a transfer edge.
REQ-026 On an advance edge with no transfer, out_valid SHALL become 0 and out_data and out_id SHALL hold their previous values.
REQ-027 Latency SHALL be 1: the result appears on the outputs in the cycle after the accepting edge.
REQ-028 Throughput SHALL be 1 result per cycle while out_ready=1.
REQ-029 When the result is consumed (out_ready=1) and a new request is pending on the same edge, the new result SHALL replace the old one with no bubble.
REQ-030 Once req_valid is asserted, the requester holds it and its operands until accepted; the block SHALL NOT require req_valid to be deasserted.
REQ-031 A requester that drops req_valid before acceptance SHALL simply be skipped, with no error indication.
REQ-032 With a single active requester, that requester SHALL be granted every advance cycle.

Reset
REQ-033 While reset=0, the block SHALL immediately, independent of clk, drive out_valid=0, out_data=0 and out_id=0.
REQ-034 While reset=0, the block SHALL hold last_grant=NUM_REQ-1, so requester 0 has first priority after release.
REQ-035 While reset=0, req_ready SHALL be 0.
REQ-036 Asserting reset mid-operation SHALL discard any in-flight result; that result SHALL NOT be presented after release.
REQ-037 The first transfer SHALL be possible on the first rising edge after reset is released.

Verification
REQ-038 Single request: req_valid=4'b0001, A=16'hFFFD (-3), B=6'h05 -> req_ready[0]=1 in that cycle; the next cycle shows out_valid=1, out_data=22'h3FFFF1 (-15), out_id=0.
REQ-039 Extreme operands: A=16'h8000 (-32768), B=6'h20 (-32) -> out_data=22'h100000 (+1048576); A=16'h7FFF, B=6'h20 -> out_data=22'h300020 (-1048544).
REQ-040 Round-robin: req_valid=4'b1111 held, out_ready=1 -> out_id sequence 0,1,2,3,0,1 on consecutive cycles, with out_valid continuously 1.
REQ-041 Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> out_data and out_id stay stable and req_ready=0; raising out_ready -> the pending requester is accepted on that same edge.
REQ-042 Skip and wrap: last_grant=2, req_valid=4'b0101 -> requester 0 is granted first (wraps past index 3), then requester 2.
REQ-043 Reset mid-stream: reset driven to 0 between clock edges while out_valid=1 -> out_valid=0, out_data=0 and out_id=0 immediately; after release with req_valid=4'b1010 -> requester 1 is granted first.
